output_serializer: RTL and testbench
====================================

# output_serializer

Egress end of the trace datapath: accepts whole N-element vectors (with EOF tag) from the filter/reduce chain in one cycle, queues them, and streams them out one DATA_WIDTH word per handshake to the narrow host/trace-port interface. It is the transmit-side counterpart of the input buffer. Word-level valid/ready backpressure on the host side; overflow detection instead of stalling on the vector side, because the upstream chain cannot stall.

## Interface
- N, 8, elements per vector
- DATA_WIDTH, 32, bits per element and per output word
- OB_DEPTH, 4, vector queue depth (power of two, ≥2)

- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- valid_in  in  1  vector_in/eof_in valid this cycle
- eof_in  in  1  vector is last of its frame
- vector_in  in  DATA_WIDTH × [N-1:0] (unpacked array)  input vector
- full_out  out  1  queue holds OB_DEPTH vectors
- occupancy_out  out  $clog2(OB_DEPTH+1)  queued vectors, excluding the one being serialized
- valid_out  out  1  data_out valid
- ready_in  in  1  host accepts word this cycle
- data_out  out  DATA_WIDTH  current element
- elem_idx_out  out  $clog2(N)  index of current element
- last_out  out  1  final word (index N-1) of a vector
- eof_out  out  1  last_out of a vector tagged eof_in
- overflow_out  out  1  sticky: a vector was dropped
- drop_count_out  out  16  dropped vectors, saturates at 16'hFFFF

## Operation
- Two stages: vector FIFO (OB_DEPTH entries of N·DATA_WIDTH+1 bits, includes eof) then serializer holding register + element counter.
- Push: valid_in=1 and full_out=0 at edge → entry written. valid_in=1 and full_out=1 → vector dropped, overflow_out set, drop_count_out+1 (saturating). full_out is evaluated before the edge; a simultaneous pop does not rescue the push.
- Serializer states: IDLE (valid_out=0), SEND (valid_out=1).
  - IDLE → SEND: FIFO non-empty; head loaded, index=0. A vector pushed into an empty FIFO with IDLE serializer bypasses nothing: it is loaded on the following edge.
  - SEND, ready_in=1, index<N-1: index+1.
  - SEND, ready_in=1, index=N-1: if FIFO non-empty, load next head, index=0, stay SEND (no bubble); else → IDLE.
  - SEND, ready_in=0: hold everything.
- Word order: element 0 first, element N-1 last.
- last_out = (index==N-1) & valid_out; eof_out = last_out & stored eof.
- Stability: while valid_out=1 and ready_in=0, data_out, elem_idx_out, last_out, eof_out must not change.

## Timing
- Reset: valid_out=0, data_out=0, elem_idx_out=0, last_out=0, eof_out=0, full_out=0, occupancy_out=0, overflow_out=0, drop_count_out=0; FIFO and holding register emptied. Reset mid-vector discards the partial vector; no further words until new pushes.
- Latency: vector pushed at edge k into empty block → valid_out=1 with element 0 in cycle after edge k+1.
- Throughput: one word per cycle with ready_in held high; consecutive vectors back-to-back, N cycles each.
- Capacity: OB_DEPTH queued + 1 in serializer.
- occupancy_out/full_out reflect registered state, updated on the edge of push/pop; pop and push on the same edge leave occupancy unchanged.

## Structure
- Shared package: vector entry typedef {eof, N×DATA_WIDTH payload}, serializer state enum, DROP_CNT_W=16.
- Sub-module: sync_vector_fifo (OB_DEPTH, entry width; push/pop/full/empty/count, wrap-around pointers with extra MSB for full/empty). Serializer FSM and overflow counters in the top.

## Test plan
- Single vector {1..8}, eof_in=1, ready_in=1 → valid_out from cycle k+2, data_out 1..8 on 8 consecutive cycles, last_out and eof_out only with 8.
- Three vectors back-to-back, ready_in=1 → 24 contiguous words, no valid_out gap, eof_out only where tagged.
- ready_in toggled 1,0,0,1,… during a vector → outputs frozen during 0 cycles; every element delivered exactly once, in order.
- ready_in=0, push 6 vectors (OB_DEPTH=4) → 1 in serializer, 4 queued, full_out=1, sixth dropped: overflow_out=1, drop_count_out=1; release ready → 5 vectors emitted.
- Push while full on the same edge as the serializer pops → still dropped, occupancy stays 4 → then 3 after next load.
- reset asserted at word 3 of a vector with 2 queued → next cycle valid_out=0, occupancy_out=0, counters 0; fresh push emits normally from element 0.

Source files
------------

// File: rtl/output_serializer_pkg.sv
// output_serializer_pkg: shared types and constants for the trace egress serializer.
package output_serializer_pkg;
  localparam int DEF_N = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OB_DEPTH = 4;
  localparam int DROP_CNT_W = 16;
  typedef enum logic {S_IDLE, S_SEND} ser_state_e;
  typedef struct packed {
    logic eof;
    logic [DEF_N-1:0][DEF_DATA_WIDTH-1:0] payload;
  } vec_entry_t;
endpackage

// File: rtl/output_serializer_fifo.sv
// sync_vector_fifo: single-clock vector queue with wrap-bit pointers for full/empty.
module sync_vector_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + ONE;
      if (pop_i && !empty_o) rptr_q <= rptr_q + ONE;
    end
  end
  always_ff @(posedge clk) if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
endmodule

// File: rtl/output_serializer.sv
// output_serializer: queues whole vectors and streams them out one word per handshake.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OB_DEPTH = DEF_OB_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  input  logic                           eof_in,
  input  logic [DATA_WIDTH-1:0]          vector_in [N-1:0],
  output logic                           full_out,
  output logic [$clog2(OB_DEPTH+1)-1:0]  occupancy_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [$clog2(N)-1:0]           elem_idx_out,
  output logic                           last_out,
  output logic                           eof_out,
  output logic                           overflow_out,
  output logic [DROP_CNT_W-1:0]          drop_count_out
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
  typedef struct packed {
    logic eof;
    logic [N-1:0][DATA_WIDTH-1:0] payload;
  } entry_t;
  entry_t in_entry, head, hold_q, hold_d;
  ser_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic empty, push, pop, at_last, ovf_q;
  logic [DROP_CNT_W-1:0] drop_q;
  always_comb begin
    in_entry.eof = eof_in;
    for (int i = 0; i < N; i++) in_entry.payload[i] = vector_in[i];
  end
  sync_vector_fifo #(.DEPTH(OB_DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .wdata_i(in_entry),
    .rdata_o(head), .full_o(full_out), .empty_o(empty), .count_o(occupancy_out)
  );
  // Full is sampled before the edge, so a same-edge pop never rescues a push.
  assign push = valid_in && !full_out;
  assign at_last = state_q == S_SEND && ready_in && idx_q == LAST_IDX;
  assign pop = !empty && (state_q == S_IDLE || at_last);
  always_comb begin
    state_d = pop ? S_SEND : (at_last ? S_IDLE : state_q);
    hold_d = pop ? head : hold_q;
    idx_d = (pop || at_last) ? '0 : (state_q == S_SEND && ready_in) ? idx_q + IW'(1) : idx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      idx_q <= idx_d;
      if (valid_in && full_out) begin
        ovf_q <= 1'b1;
        drop_q <= (&drop_q) ? drop_q : drop_q + DROP_CNT_W'(1);
      end
    end
  end
  assign valid_out = state_q == S_SEND;
  assign data_out = valid_out ? hold_q.payload[idx_q] : '0;
  assign elem_idx_out = idx_q;
  assign last_out = valid_out && idx_q == LAST_IDX;
  assign eof_out = last_out && hold_q.eof;
  assign overflow_out = ovf_q;
  assign drop_count_out = drop_q;
endmodule

// File: tb/tb_output_serializer.sv
// tb_output_serializer: directed table plus hand sequences for the egress serializer.
module tb_output_serializer;
  localparam int N = 8;
  localparam int DW = 32;
  localparam int D = 4;
  typedef struct {
    logic v; logic e; logic [31:0] base; logic r;
    logic ev; logic [31:0] ed; logic [2:0] ei; logic el; logic ee; logic [2:0] eo; logic ef;
  } row_t;
  typedef struct {logic [31:0] d; logic l; logic e;} word_t;
  logic clk = 1'b0;
  logic reset, valid_in, eof_in, ready_in;
  logic [DW-1:0] vector_in [N-1:0];
  logic full_out, valid_out, last_out, eof_out, overflow_out;
  logic [2:0] occupancy_out, elem_idx_out;
  logic [DW-1:0] data_out;
  logic [15:0] drop_count_out;
  int n_cmp = 0;
  int n_err = 0;
  word_t exp_q[$];
  row_t tbl[23];
  always #5 clk = ~clk;
  output_serializer #(.N(N), .DATA_WIDTH(DW), .OB_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in), .vector_in(vector_in),
    .full_out(full_out), .occupancy_out(occupancy_out), .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .elem_idx_out(elem_idx_out), .last_out(last_out), .eof_out(eof_out),
    .overflow_out(overflow_out), .drop_count_out(drop_count_out)
  );
  function automatic row_t R(input logic v, input logic e, input logic [31:0] base, input logic r,
                             input logic ev, input logic [31:0] ed, input logic [2:0] ei,
                             input logic el, input logic ee, input logic [2:0] eo, input logic ef);
    row_t x;
    x.v = v; x.e = e; x.base = base; x.r = r; x.ev = ev; x.ed = ed;
    x.ei = ei; x.el = el; x.ee = ee; x.eo = eo; x.ef = ef;
    return x;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic e, input logic [31:0] base);
    valid_in = v;
    eof_in = e;
    for (int i = 0; i < N; i++) vector_in[i] = base + i;
  endtask
  task automatic expect_vec(input logic [31:0] base, input logic e);
    for (int i = 0; i < N; i++) exp_q.push_back('{base + i, i == N-1, e && i == N-1});
  endtask
  task automatic check_word;
    word_t w;
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected none", data_out);
      end else begin
        w = exp_q.pop_front();
        chk("word_data", data_out, w.d);
        chk("word_last", {31'd0, last_out}, {31'd0, w.l});
        chk("word_eof", {31'd0, eof_out}, {31'd0, w.e});
      end
    end
  endtask
  task automatic drain(input string name, input int max_cycles);
    for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
      check_word();
      tick();
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int gaps, cyc;
    reset = 1'b1;
    ready_in = 1'b0;
    drive(0, 0, 0);
    tick();
    tick();
    chk("rst_valid", {31'd0, valid_out}, 0);
    chk("rst_data", data_out, 0);
    chk("rst_idx", {29'd0, elem_idx_out}, 0);
    chk("rst_last", {31'd0, last_out}, 0);
    chk("rst_eof", {31'd0, eof_out}, 0);
    chk("rst_full", {31'd0, full_out}, 0);
    chk("rst_occ", {29'd0, occupancy_out}, 0);
    chk("rst_ovf", {31'd0, overflow_out}, 0);
    chk("rst_drop", {16'd0, drop_count_out}, 0);
    reset = 1'b0;
    // single vector 1..8 then a backpressured vector 0x10..0x17
    tbl[0] = R(1, 1, 32'h1, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[1] = R(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 8; k++) tbl[k] = R(0, 0, 0, 1, 1, k, 3'(k-1), k == 8, k == 8, 0, 0);
    tbl[9]  = R(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = R(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[11] = R(0, 0, 0, 1, 1, 32'h10, 0, 0, 0, 0, 0);
    tbl[12] = R(0, 0, 0, 1, 1, 32'h11, 1, 0, 0, 0, 0);
    tbl[13] = R(0, 0, 0, 0, 1, 32'h11, 1, 0, 0, 0, 0);
    tbl[14] = R(0, 0, 0, 0, 1, 32'h11, 1, 0, 0, 0, 0);
    tbl[15] = R(0, 0, 0, 1, 1, 32'h12, 2, 0, 0, 0, 0);
    tbl[16] = R(0, 0, 0, 0, 1, 32'h12, 2, 0, 0, 0, 0);
    tbl[17] = R(0, 0, 0, 1, 1, 32'h13, 3, 0, 0, 0, 0);
    tbl[18] = R(0, 0, 0, 1, 1, 32'h14, 4, 0, 0, 0, 0);
    tbl[19] = R(0, 0, 0, 1, 1, 32'h15, 5, 0, 0, 0, 0);
    tbl[20] = R(0, 0, 0, 1, 1, 32'h16, 6, 0, 0, 0, 0);
    tbl[21] = R(0, 0, 0, 1, 1, 32'h17, 7, 1, 0, 0, 0);
    tbl[22] = R(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 23; k++) begin
      drive(tbl[k].v, tbl[k].e, tbl[k].base);
      ready_in = tbl[k].r;
      tick();
      valid_in = 1'b0;
      chk($sformatf("row%0d_valid", k), {31'd0, valid_out}, {31'd0, tbl[k].ev});
      chk($sformatf("row%0d_data", k), data_out, tbl[k].ed);
      chk($sformatf("row%0d_idx", k), {29'd0, elem_idx_out}, {29'd0, tbl[k].ei});
      chk($sformatf("row%0d_last", k), {31'd0, last_out}, {31'd0, tbl[k].el});
      chk($sformatf("row%0d_eof", k), {31'd0, eof_out}, {31'd0, tbl[k].ee});
      chk($sformatf("row%0d_occ", k), {29'd0, occupancy_out}, {29'd0, tbl[k].eo});
      chk($sformatf("row%0d_full", k), {31'd0, full_out}, {31'd0, tbl[k].ef});
    end
    // three vectors back-to-back: 24 contiguous words
    ready_in = 1'b1;
    expect_vec(32'h100, 0);
    expect_vec(32'h200, 1);
    expect_vec(32'h300, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, k == 1, 32'h100 * (k + 1));
      check_word();
      tick();
    end
    valid_in = 1'b0;
    gaps = 0;
    cyc = 0;
    while (cyc < 60 && exp_q.size() > 0) begin
      if (!valid_out) gaps++;
      check_word();
      tick();
      cyc++;
    end
    chk("b_drained", exp_q.size(), 0);
    chk("b_gaps", gaps, 0);
    chk("b_cycles", cyc, 23);
    chk("b_idle", {31'd0, valid_out}, 0);
    // fill with ready low, overflow, then drops on same-edge pops
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) expect_vec(32'h1000 * (k + 1), k == 3);
    for (int k = 0; k < 6; k++) begin
      drive(1, k == 3, 32'h1000 * (k + 1));
      tick();
    end
    valid_in = 1'b0;
    chk("c_full", {31'd0, full_out}, 1);
    chk("c_occ", {29'd0, occupancy_out}, 4);
    chk("c_ovf", {31'd0, overflow_out}, 1);
    chk("c_drop1", {16'd0, drop_count_out}, 1);
    chk("c_valid", {31'd0, valid_out}, 1);
    chk("c_data", data_out, 32'h1000);
    drive(1, 0, 32'hDEAD0000);
    ready_in = 1'b1;
    check_word();
    tick();
    valid_in = 1'b0;
    chk("c_drop2", {16'd0, drop_count_out}, 2);
    chk("c_occ_mid", {29'd0, occupancy_out}, 4);
    chk("c_idx1", {29'd0, elem_idx_out}, 1);
    for (int k = 0; k < 6; k++) begin
      check_word();
      tick();
    end
    chk("c_idx7", {29'd0, elem_idx_out}, 7);
    drive(1, 0, 32'hBEEF0000);
    check_word();
    tick();
    valid_in = 1'b0;
    chk("c_drop3", {16'd0, drop_count_out}, 3);
    chk("c_occ_load", {29'd0, occupancy_out}, 3);
    chk("c_full_load", {31'd0, full_out}, 0);
    chk("c_idx_load", {29'd0, elem_idx_out}, 0);
    chk("c_data_load", data_out, 32'h2000);
    drain("c", 100);
    tick();
    chk("c_idle", {31'd0, valid_out}, 0);
    chk("c_occ_end", {29'd0, occupancy_out}, 0);
    // reset mid-vector with two queued
    drive(1, 0, 32'h7000);
    tick();
    drive(1, 0, 32'h7100);
    tick();
    drive(1, 1, 32'h7200);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    chk("d_idx_pre", {29'd0, elem_idx_out}, 3);
    chk("d_occ_pre", {29'd0, occupancy_out}, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("d_valid", {31'd0, valid_out}, 0);
    chk("d_occ", {29'd0, occupancy_out}, 0);
    chk("d_full", {31'd0, full_out}, 0);
    chk("d_ovf", {31'd0, overflow_out}, 0);
    chk("d_drop", {16'd0, drop_count_out}, 0);
    chk("d_idx", {29'd0, elem_idx_out}, 0);
    chk("d_data", data_out, 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("d_quiet", {31'd0, valid_out}, 0);
    end
    expect_vec(32'h9000, 1);
    drive(1, 1, 32'h9000);
    tick();
    valid_in = 1'b0;
    chk("d_lat0", {31'd0, valid_out}, 0);
    tick();
    chk("d_lat1", {31'd0, valid_out}, 1);
    chk("d_first_idx", {29'd0, elem_idx_out}, 0);
    drain("d", 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
